pipeline_flow_ctrl: RTL and testbench

Sequencing controller for the pipelined MIPS CPU's PC path. It owns the PC `enable` input and the pipeline-register enable/flush strobes, and resolves three event sources: load-use hazards, taken branches/jumps reported by `PC.branch`, and syscall halt. It also keeps run, stall and flush statistics for the Nexys 4 DDR display. It sits between hazard detection/decode and the PC, IF/ID and ID/EX registers.

---
 rtl/pipeline_flow_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_flow_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_flow_ctrl.sv
// PC-path sequencing controller: resolves halt, taken branch and load-use events into
// PC/IF-ID/ID-EX strobes, and keeps run/stall/flush statistics.
module pipeline_flow_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch,
    input  logic             halt,
    input  logic             go,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       go_q;
    logic       go_rise;
    logic       cycle_inc;
    logic       stall_inc;
    logic       flush_inc;

    assign go_rise = go & ~go_q;

    // Priority in RUN: halt > branch > load_use. Strobes are all low while rst is held.
    always_comb begin
        state_next  = state;
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        running     = 1'b0;
        cycle_inc   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!rst) begin
            if (state == RUN) begin
                running   = 1'b1;
                cycle_inc = 1'b1;
                if (halt) begin
                    idex_flush = 1'b1;
                    state_next = HALTED;
                end else if (branch) begin
                    // Instruction in ID is squashed, so a coincident load_use is moot.
                    pc_enable   = 1'b1;
                    ifid_enable = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else begin
                    pc_enable   = 1'b1;
                    ifid_enable = 1'b1;
                end
            end else begin
                // Bubbles drain MEM/WB while PC and IF/ID stay frozen.
                idex_flush = 1'b1;
                if (go_rise) begin
                    state_next = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            go_q      <= 1'b1;  // a button held through reset must not count as a press
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            go_q  <= go;
            if (cycle_inc) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: a vector table for the main flow, then
// hand-written sequences for reset-in-HALTED and counter wrap.
module tb_pipeline_flow_ctrl;

    logic        clk;
    logic        rst;
    logic        load_use;
    logic        branch;
    logic        halt;
    logic        go;
    logic        pc_enable, ifid_enable, ifid_flush, idex_flush, running;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic        pc_enable4, ifid_enable4, ifid_flush4, idex_flush4, running4;
    logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       lu;
        logic       br;
        logic       ht;
        logic       g;
        logic [4:0] exp;  // {pc_enable, ifid_enable, ifid_flush, idex_flush, running}
    } vec_t;

    vec_t vecs[$];

    pipeline_flow_ctrl dut (
        .clk(clk), .rst(rst), .load_use(load_use), .branch(branch), .halt(halt), .go(go),
        .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .running(running), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_flow_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .load_use(load_use), .branch(branch), .halt(halt), .go(go),
        .pc_enable(pc_enable4), .ifid_enable(ifid_enable4), .ifid_flush(ifid_flush4),
        .idex_flush(idex_flush4), .running(running4), .cycle_cnt(cycle_cnt4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {pc_enable, ifid_enable, ifid_flush, idex_flush, running};
    endfunction

    task automatic add(input logic lu, input logic br, input logic ht, input logic g,
                       input logic [4:0] exp);
        vec_t v;
        v.lu = lu; v.br = br; v.ht = ht; v.g = g; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive inputs, compare strobes mid-cycle, then advance past the next rising edge.
    task automatic step(input logic lu, input logic br, input logic ht, input logic g,
                        input logic [4:0] exp, input string name);
        load_use = lu; branch = br; halt = ht; go = g;
        @(negedge clk);
        chk(name, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] O_RUN   = 5'b11001;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_FLUSH = 5'b11111;
    localparam logic [4:0] O_HDET  = 5'b00011;
    localparam logic [4:0] O_HALT  = 5'b00010;
    localparam logic [4:0] O_RST   = 5'b00000;

    initial begin
        // 0-9: free run with go held from reset
        for (int i = 0; i < 10; i++) add(0, 0, 0, 1, O_RUN);
        add(1, 0, 0, 1, O_STALL);   // 10
        add(0, 1, 0, 1, O_FLUSH);   // 11
        add(1, 1, 0, 1, O_FLUSH);   // 12 branch wins over load_use
        add(0, 0, 0, 0, O_RUN);     // 13
        add(0, 0, 1, 0, O_HDET);    // 14 halt detect
        add(0, 0, 0, 0, O_HALT);    // 15
        add(0, 1, 0, 0, O_HALT);    // 16 branch ignored in HALTED
        add(1, 0, 0, 0, O_HALT);    // 17 load_use ignored in HALTED
        add(0, 0, 0, 0, O_HALT);    // 18
        add(0, 0, 0, 1, O_HALT);    // 19 go rise, still halted this cycle
        add(0, 0, 0, 1, O_RUN);     // 20 resumed
        add(0, 0, 1, 1, O_HDET);    // 21 halt with go held
        add(0, 0, 0, 1, O_HALT);    // 22 held go does not resume
        add(0, 0, 0, 1, O_HALT);    // 23
        add(0, 0, 0, 0, O_HALT);    // 24 release
        add(0, 0, 0, 1, O_HALT);    // 25 press
        add(0, 0, 0, 1, O_RUN);     // 26

        rst = 1'b1; load_use = 0; branch = 0; halt = 0; go = 1'b1;
        @(negedge clk);
        chk("rst_outs", 32'(outs()), 32'(O_RST));
        @(posedge clk);
        #1;
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].lu, vecs[i].br, vecs[i].ht, vecs[i].g, vecs[i].exp,
                 $sformatf("vec%0d", i));
            if (i == 9) begin
                chk("free_cycle_cnt", cycle_cnt, 10);
                chk("free_stall_cnt", stall_cnt, 0);
                chk("free_flush_cnt", flush_cnt, 0);
            end
            if (i == 12) begin
                chk("mix_stall_cnt", stall_cnt, 1);
                chk("mix_flush_cnt", flush_cnt, 2);
            end
        end
        // RUN cycles: vectors 0-14, 20, 21, 26
        chk("tbl_cycle_cnt", cycle_cnt, 18);
        chk("tbl_stall_cnt", stall_cnt, 1);
        chk("tbl_flush_cnt", flush_cnt, 2);
        chk("tbl_cycle_cnt4", 32'(cycle_cnt4), 2);

        // Reset while HALTED returns to RUN with cleared counters, no go needed.
        step(0, 0, 1, 0, O_HDET, "seq_halt");
        step(0, 0, 0, 0, O_HALT, "seq_halted");
        rst = 1'b1;
        @(negedge clk);
        chk("seq_rst_outs", 32'(outs()), 32'(O_RST));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("seq_rst_running", 32'(running), 1);
        chk("seq_rst_pc_enable", 32'(pc_enable), 1);
        chk("seq_rst_cycle_cnt", cycle_cnt, 0);

        // Sixteen taken branches wrap a 4-bit counter to zero.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, O_FLUSH, $sformatf("wrap_br%0d", i));
        chk("wrap_flush_cnt4", 32'(flush_cnt4), 0);
        chk("wrap_cycle_cnt4", 32'(cycle_cnt4), 0);
        chk("wrap_flush_cnt", flush_cnt, 16);
        chk("wrap_cycle_cnt", cycle_cnt, 16);
        step(0, 1, 0, 0, O_FLUSH, "wrap_br16");
        chk("wrap_flush_cnt4_1", 32'(flush_cnt4), 1);

        // Held load_use: k cycles gives k stalls.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, O_STALL, $sformatf("lu_hold%0d", i));
        chk("lu_hold_stall_cnt", stall_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
